clmul_limb_seq: RTL and testbench
=================================

Name: clmul_limb_seq

Overview:
Sequential carry-less (GF(2)) polynomial multiplier for wide operands.
- Splits both operands into 3-bit limbs and schoolbooks over every limb pair, one pair per clock.
- Each pair goes through one shared ks3 core (3x3 carry-less multiply, 5-bit product); the 5-bit partial products are XOR-accumulated at the correct shift.
- Sits directly downstream of ks3 as its consumer/accumulator and feeds later reduction/Toom-interpolation stages over a valid/ready handshake.

Parameters:
LIMBS, 4, number of 3-bit limbs per operand (>=1); operand width W = 3*LIMBS.
PW, 6*LIMBS-1, derived product width; not overridable.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair offered
in_ready  output  1  block can accept operands
a  input  W  operand A; bit i = coefficient of x^i
b  input  W  operand B; same encoding
out_valid  output  1  product d is valid
out_ready  input  1  consumer accepts d
d  output  PW  carry-less product A*B
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, d=0, limb counters=0, operand registers=0. Any operation in flight is abandoned; no output is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch a and b, clear the accumulator, set i=j=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: drive a_i=A[3i+2:3i] and b_j=B[3j+2:3j] into ks3.
  - acc[3(i+j)+4 : 3(i+j)] ^= product. Pure XOR, no carries.
  - Indices: j increments; when j wraps from LIMBS-1 to 0, i increments.
  - On the cycle that processes (LIMBS-1, LIMBS-1): go to DONE.
- DONE:
  - out_valid=1; d=acc, held stable while out_valid=1 and out_ready=0.
  - On out_ready=1: go to IDLE, out_valid=0 next cycle.
- Latency:
  - Handshake in cycle 0; MAC cycles 1..LIMBS^2; out_valid rises in cycle LIMBS^2+1 (17 for LIMBS=4).
  - Throughput: one product per LIMBS^2+2 cycles minimum.
- No input/output overlap: in_ready=0 in RUN and DONE. A new in_valid during DONE waits until IDLE, so it is accepted no earlier than the cycle after the output handshake.
- in_valid asserted with in_ready=0: ignored; the a/b inputs are not sampled.
- Width rule: the accumulator is exactly PW bits. The top limb-pair product (bits PW-1..PW-5) never overflows, because the product degree is <= 6*LIMBS-2.
- d is a registered output: it changes only on entering DONE or on reset, and is not cleared on leaving DONE.
- LIMBS=1: single MAC cycle; d equals the ks3 product.
- All-zero operands: d=0 after full latency; no early exit.
- ks3 is purely combinational; its output is registered only through the accumulator. No extra pipeline stage.

Decomposition:
- Shared package (clmul_pkg):
  - LIMB_W=3 and LIMB_PW=5 constants.
  - State enum IDLE/RUN/DONE.
  - Function computing the shift offset 3*(i+j).
- One sub-module: ks3 (existing combinational core), instantiated once.
- Index counters and accumulator stay in clmul_limb_seq.

Test Plan:
- LIMBS=4, a=0x001, b=0x001 -> out_valid at cycle 17 after accept; d=0x000001.
- a=0x007 (1+x+x^2), b=0x003 (1+x) -> d=0x000009 (1+x^3, carry-less).
- a=0xFFF, b=0xFFF -> d=0x555555 (GF(2) squaring: even bits 0..22 only).
- a=0x800, b=0x800 -> d=0x400000 (top-bit boundary).
- Backpressure: a=0x5A3, b=0x3C1, out_ready=0 for 10 cycles after out_valid -> d and out_valid stable throughout; in_ready=0 until the cycle after the out_ready handshake. Compare against a bitwise carry-less reference model.
- Reset mid-RUN: deassert rst_n at MAC cycle 6 -> out_valid=0, in_ready=1, d=0 immediately. A following a=0x002, b=0x002 -> d=0x000004 with no residue from the aborted operation.

Source files
------------

// File: rtl/clmul_pkg.sv
// Shared constants, state encoding and shift helper for the limb-serial
// carry-less multiplier.
package clmul_pkg;

  localparam int LIMB_W  = 3;
  localparam int LIMB_PW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit offset of the partial product for limb pair (i, j).
  function automatic int clmul_off(input int i, input int j);
    return LIMB_W * (i + j);
  endfunction

endpackage

// File: rtl/ks3.sv
// 3x3 carry-less multiply core: purely combinational, 5-bit GF(2) product.
module ks3
  import clmul_pkg::*;
(
  input  logic [LIMB_W-1:0]  a,
  input  logic [LIMB_W-1:0]  b,
  output logic [LIMB_PW-1:0] p
);

  // Each product bit k is the XOR of every a[i]&b[j] with i+j == k.
  always_comb begin
    p = '0;
    for (int i = 0; i < LIMB_W; i++) begin
      for (int j = 0; j < LIMB_W; j++) begin
        p[i+j] = p[i+j] ^ (a[i] & b[j]);
      end
    end
  end

endmodule

// File: rtl/clmul_limb_seq.sv
// Limb-serial schoolbook carry-less multiplier: one 3x3 limb pair per clock
// through a shared ks3 core, XOR-accumulated at offset 3*(i+j).
module clmul_limb_seq
  import clmul_pkg::*;
#(
  parameter  int LIMBS = 4,
  localparam int W     = LIMB_W * LIMBS,
  localparam int PW    = 2 * W - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] d,
  output logic          busy
);

  localparam int IW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [IW-1:0] LAST = IW'(LIMBS - 1);

  state_t                         st;
  logic [LIMBS-1:0][LIMB_W-1:0]   a_q, b_q;
  logic [IW-1:0]                  i_q, j_q;
  logic [PW-1:0]                  acc, acc_nxt;
  logic [LIMB_W-1:0]              a_limb, b_limb;
  logic [LIMB_PW-1:0]             prod;
  logic                           last;

  assign a_limb = a_q[i_q];
  assign b_limb = b_q[j_q];
  assign last   = (i_q == LAST) && (j_q == LAST);

  ks3 u_ks3 (
    .a (a_limb),
    .b (b_limb),
    .p (prod)
  );

  // Fold the current partial product into the accumulator at its limb offset.
  // The top pair lands on bits PW-1..PW-5, so no bits fall off the end.
  always_comb begin
    acc_nxt = acc ^ (PW'(prod) << clmul_off(int'(i_q), int'(j_q)));
  end

  // Control FSM with registered handshake outputs; d loads only on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      d         <= '0;
      acc       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            acc      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            st       <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          if (last) begin
            d         <= acc_nxt;
            out_valid <= 1'b1;
            st        <= DONE;
          end else if (j_q == LAST) begin
            j_q <= '0;
            i_q <= i_q + IW'(1);
          end else begin
            j_q <= j_q + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            st        <= IDLE;
          end
        end
        default: begin
          st        <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clmul_limb_seq.sv
// Scoreboard bench for clmul_limb_seq (LIMBS=4): expected products from a
// bitwise carry-less model are queued at accept and popped at out_valid.
module tb_clmul_limb_seq;

  localparam int LIMBS = 4;
  localparam int W     = 3 * LIMBS;
  localparam int PW    = 2 * W - 1;
  localparam int LAT   = LIMBS * LIMBS + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] d;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [PW-1:0] sb_q[$];

  always #5 clk = ~clk;

  clmul_limb_seq #(.LIMBS(LIMBS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .busy      (busy)
  );

  function automatic logic [PW-1:0] clmul_ref(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [PW-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++)
      if (y[k]) r = r ^ (PW'(x) << k);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair; returns once it has been accepted (bounded wait).
  task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("in_ready_wait", in_ready, 1'b1);
    a        = ta;
    b        = tb;
    in_valid = 1'b1;
    sb_q.push_back(clmul_ref(ta, tb));
    tick();
    in_valid = 1'b0;
  endtask

  // Full operation: accept, measure latency, hold off out_ready for `hold`
  // cycles while checking stability, then complete the output handshake.
  // With poke set, in_valid is driven with junk operands while busy.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input int hold, input bit poke, input string nm);
    int lat;
    logic [PW-1:0] exp;
    accept(ta, tb);
    lat = 1;
    if (poke) begin
      in_valid = 1'b1;
      a = ~ta;
      b = tb ^ W'(12'h5A5);
    end
    chk({nm, "_busy_run"}, {in_ready, busy}, 2'b01);
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk({nm, "_latency"}, lat, LAT);
    chk({nm, "_sb_nonempty"}, sb_q.size() != 0, 1'b1);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    chk({nm, "_d"}, d, exp);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({nm, "_hold"}, {out_valid, in_ready, busy, d}, {3'b101, exp});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, "_post_hs"}, {out_valid, in_ready, busy, d}, {3'b010, exp});
  endtask

  initial begin
    // Reset state.
    #12;
    chk("rst_state", {in_ready, out_valid, busy, d}, {3'b100, {PW{1'b0}}});
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op(12'h001, 12'h001, 0, 1'b0, "unit");
    run_op(12'h007, 12'h003, 0, 1'b0, "x7x3");
    chk("x7x3_const", d, 23'h000009);
    run_op(12'hFFF, 12'hFFF, 0, 1'b0, "sqr_ones");
    chk("sqr_ones_const", d, 23'h555555);
    run_op(12'h000, 12'hABC, 0, 1'b0, "zero");
    run_op(12'h5A3, 12'h3C1, 10, 1'b1, "bp");
    run_op(12'h800, 12'h800, 0, 1'b0, "topbit");
    chk("topbit_const", d, 23'h400000);

    // Reset during MAC cycle 6: everything clears at once, nothing emerges.
    accept(12'hFED, 12'h9B7);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_state", {out_valid, in_ready, busy, d}, {3'b010, {PW{1'b0}}});
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      tick();
      chk("midrst_no_out", out_valid, 1'b0);
    end
    run_op(12'h002, 12'h002, 0, 1'b0, "post_rst");
    chk("post_rst_const", d, 23'h000004);

    // A few random pairs against the reference model.
    for (int r = 0; r < 6; r++)
      run_op(W'($urandom_range(0, 4095)), W'($urandom_range(0, 4095)),
             int'($urandom_range(0, 3)), 1'(r & 1), "rand");

    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
